full_adder: RTL and testbench
=============================

# full_adder

One-bit full adder with a registered output stage, a saturating carry-event counter and an optional bit-serial carry-chaining mode. It is the leaf arithmetic cell of the datapath. The sum and carry outputs are purely combinational so the cell can be chained directly. The registered outputs and the counter let the cell be pipelined and monitored on the system clock.

## Interface
- CNT_W, default 8: width of the carry-event counter.
- clk  input  1  system clock; all state updates occur on the rising edge.
- rst  input  1  asynchronous reset, active high; clears all state.
- a  input  1  addend bit.
- b  input  1  addend bit.
- cin  input  1  carry-in bit.
- in_valid  input  1  qualifies a, b and cin for the registered stage, the counter and the serial state.
- ser_mode  input  1  selects bit-serial chaining. Ignored when the serial feature is compiled out.
- ser_start  input  1  marks the LSB of a serial word. Ignored when the serial feature is compiled out.
- cnt_clr  input  1  synchronous clear of carry_cnt.
- sum  output  1  combinational sum bit.
- carry  output  1  combinational carry-out bit.
- sum_q  output  1  registered sum.
- carry_q  output  1  registered carry.
- out_valid  output  1  registered in_valid.
- carry_cnt  output  CNT_W  saturating count of valid cycles with carry = 1.

## Operation
- cin_eff = cin, except in serial mode (see below).
- sum = a ^ b ^ cin_eff.
- carry = (a & b) | (a & cin_eff) | (b & cin_eff).
- The combinational outputs update with no clock involvement. They hold for any input values regardless of in_valid, clk and rst.
- Truth table, with cin_eff = cin:
  - 000 gives sum 0, carry 0.
  - 001, 010 and 100 give sum 1, carry 0.
  - 011, 101 and 110 give sum 0, carry 1.
  - 111 gives sum 1, carry 1.
- Registered stage:
  - out_valid <= in_valid every cycle.
  - When in_valid = 1: sum_q <= sum and carry_q <= carry.
  - When in_valid = 0: sum_q and carry_q hold their values.
- Counter:
  - When cnt_clr = 1: carry_cnt <= 0. cnt_clr has priority over increment.
  - Otherwise, when in_valid & carry: carry_cnt <= carry_cnt + 1.
  - The counter saturates at 2^CNT_W - 1 and never wraps.
- Serial mode (feature compiled in, ser_mode = 1):
  - Internal register ser_c holds the chained carry.
  - cin_eff = ser_start ? cin : ser_c.
  - When in_valid = 1: ser_c <= carry.
  - When in_valid = 0: ser_c holds.
  - When ser_mode = 0, ser_c is not updated and cin_eff = cin.

## Timing
- Combinational path: a, b, cin, ser_start and ser_c drive sum and carry with zero cycle latency.
- Registered path: sum_q, carry_q and out_valid have a latency of 1 cycle.
- carry_cnt reflects a qualifying cycle 1 cycle later.
- Reset values: sum_q = 0, carry_q = 0, out_valid = 0, carry_cnt = 0, ser_c = 0.
- Reset is asynchronous. It takes effect immediately, mid-operation included.
- sum and carry are unaffected by reset except through ser_c.
- Simultaneous events:
  - cnt_clr together with a qualifying carry gives 0.
  - ser_start together with in_valid uses cin and then loads ser_c from the resulting carry.
- Back-to-back in_valid cycles are fully supported, one bit per cycle.

## Configuration
- FULL_ADDER_SERIAL_EN defined:
  - ser_c and the serial mux are built.
  - ser_mode and ser_start behave as described in Operation.
- FULL_ADDER_SERIAL_EN undefined:
  - ser_mode and ser_start remain as ports but are ignored.
  - cin_eff = cin always and no ser_c register exists.

## Test plan
- Exhaustive sweep: apply abc = 000 through 111 at 10 time-unit steps with in_valid = 0 -> sum/carry = 0/0, 1/0, 1/0, 0/1, 1/0, 0/1, 0/1, 1/1; out_valid stays 0.
- Registered path: a=1, b=1, cin=0 with in_valid = 1 for one cycle -> next cycle sum_q = 0, carry_q = 1, out_valid = 1; after in_valid drops, sum_q and carry_q hold while out_valid = 0.
- Counter: CNT_W = 2, five consecutive valid cycles with a=b=1 -> carry_cnt reads 1, 2, 3, 3, 3; then cnt_clr = 1 together with a valid carry -> 0.
- Async reset: assert rst between clock edges after loading sum_q = 1 and carry_cnt = 2 -> sum_q, carry_q, out_valid and carry_cnt read 0 immediately, with no clock edge.
- Serial (macro defined): ser_mode = 1; add 3 + 1 LSB-first over 4 valid cycles with ser_start on bit 0 and cin = 0 -> sum bits 0, 0, 1, 0 (value 4) with ser_c chaining correctly.
- Serial (macro undefined): ser_mode = 1 and ser_start = 0 with a=0, b=0, cin=1 following a carry -> sum = 1, carry = 0, confirming cin is used directly.

Source files
------------

// File: rtl/full_adder_if.sv
// Bundle of the full_adder data, control and status signals; the clock and reset stay outside.
// in_valid qualifies a/b/cin for one cycle with no backpressure; out_valid follows it one cycle later.
interface full_adder_if #(
    parameter int CNT_W = 8
);
    logic             a;
    logic             b;
    logic             cin;
    logic             in_valid;
    logic             ser_mode;
    logic             ser_start;
    logic             cnt_clr;
    logic             sum;
    logic             carry;
    logic             sum_q;
    logic             carry_q;
    logic             out_valid;
    logic [CNT_W-1:0] carry_cnt;

    modport master (
        output a, b, cin, in_valid, ser_mode, ser_start, cnt_clr,
        input  sum, carry, sum_q, carry_q, out_valid, carry_cnt
    );

    modport slave (
        input  a, b, cin, in_valid, ser_mode, ser_start, cnt_clr,
        output sum, carry, sum_q, carry_q, out_valid, carry_cnt
    );
endinterface

// File: rtl/full_adder.sv
// One-bit full adder with a registered stage and a saturating carry-event counter.
// Define FULL_ADDER_SERIAL_EN to build the bit-serial carry chain (ser_c register and cin mux).
module full_adder #(
    parameter int CNT_W = 8
) (
    input logic        clk,
    input logic        rst,
    full_adder_if.slave bus
);
    logic cin_eff;

`ifdef FULL_ADDER_SERIAL_EN
    logic ser_c;

    // The LSB of a serial word takes the external carry-in; later bits take the chained carry.
    assign cin_eff = (bus.ser_mode && !bus.ser_start) ? ser_c : bus.cin;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ser_c <= 1'b0;
        end else if (bus.ser_mode && bus.in_valid) begin
            ser_c <= bus.carry;
        end
    end
`else
    logic unused_ser;

    assign cin_eff    = bus.cin;
    assign unused_ser = bus.ser_mode ^ bus.ser_start;
`endif

    assign bus.sum   = bus.a ^ bus.b ^ cin_eff;
    assign bus.carry = (bus.a & bus.b) | (bus.a & cin_eff) | (bus.b & cin_eff);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.sum_q     <= 1'b0;
            bus.carry_q   <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.sum_q   <= bus.sum;
                bus.carry_q <= bus.carry;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.carry_cnt <= '0;
        end else if (bus.cnt_clr) begin
            bus.carry_cnt <= '0;
        end else if (bus.in_valid && bus.carry && (bus.carry_cnt != {CNT_W{1'b1}})) begin
            bus.carry_cnt <= bus.carry_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: truth-table sweep, registered path, counter saturation,
// asynchronous reset and the serial carry chain (branch chosen by FULL_ADDER_SERIAL_EN).
module tb_full_adder;
    localparam int CNT_W = 2;

    typedef struct {
        logic a;
        logic b;
        logic cin;
        logic sum;
        logic carry;
    } vec_t;

    logic clk;
    logic rst;
    full_adder_if #(.CNT_W(CNT_W)) bus ();

    full_adder #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state and scoreboard of registered outputs {out_valid, sum_q, carry_q, carry_cnt}
    logic             m_ov, m_sq, m_cq, m_ser_c;
    logic [CNT_W-1:0] m_cnt;
    logic [CNT_W+2:0] exp_q[$];
    logic             last_s, last_c;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    task automatic model_reset();
        m_ov = 1'b0; m_sq = 1'b0; m_cq = 1'b0; m_cnt = '0; m_ser_c = 1'b0;
        exp_q.delete();
    endtask

    // Drive one cycle of inputs, check the combinational outputs, then the registered outputs after the edge.
    task automatic step(input logic ai, input logic bi, input logic ci, input logic vi,
                        input logic clr, input logic smode, input logic sstart);
        logic ce, s, c;
        logic [CNT_W+2:0] exp_w;
        bus.a = ai; bus.b = bi; bus.cin = ci; bus.in_valid = vi;
        bus.cnt_clr = clr; bus.ser_mode = smode; bus.ser_start = sstart;
        ce = ci;
`ifdef FULL_ADDER_SERIAL_EN
        if (smode && !sstart) ce = m_ser_c;
`endif
        s = ai ^ bi ^ ce;
        c = (ai & bi) | (ai & ce) | (bi & ce);
        #1;
        check("comb_sum", {7'd0, bus.sum}, {7'd0, s});
        check("comb_carry", {7'd0, bus.carry}, {7'd0, c});
        last_s = bus.sum;
        last_c = bus.carry;
        m_ov = vi;
        if (vi) begin
            m_sq = s;
            m_cq = c;
        end
        if (clr) m_cnt = '0;
        else if (vi && c && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
        if (smode && vi) m_ser_c = c;
        exp_q.push_back({m_ov, m_sq, m_cq, m_cnt});
        @(posedge clk);
        #1;
        exp_w = exp_q.pop_front();
        check("registered", {3'd0, bus.out_valid, bus.sum_q, bus.carry_q, bus.carry_cnt},
              {3'd0, exp_w});
    endtask

    vec_t vecs[8];
    logic [1:0] cnt_exp[5];
    logic       ser_exp[4];
    logic       ser_a[4];
    logic       ser_b[4];

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        cnt_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        ser_a   = '{1'b1, 1'b1, 1'b0, 1'b0};
        ser_b   = '{1'b1, 1'b0, 1'b0, 1'b0};
        ser_exp = '{1'b0, 1'b0, 1'b1, 1'b0};

        bus.a = 0; bus.b = 0; bus.cin = 0; bus.in_valid = 0;
        bus.ser_mode = 0; bus.ser_start = 0; bus.cnt_clr = 0;
        rst = 1'b1;
        model_reset();
        #12;
        check("reset_regs", {3'd0, bus.out_valid, bus.sum_q, bus.carry_q, bus.carry_cnt}, 8'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Truth-table sweep with in_valid low: combinational outputs only, registered stage idle
        for (int i = 0; i < 8; i++) begin
            bus.a = vecs[i].a; bus.b = vecs[i].b; bus.cin = vecs[i].cin;
            #1;
            check("sweep_sum", {7'd0, bus.sum}, {7'd0, vecs[i].sum});
            check("sweep_carry", {7'd0, bus.carry}, {7'd0, vecs[i].carry});
            check("sweep_out_valid", {7'd0, bus.out_valid}, 8'd0);
            #9;
        end
        @(posedge clk);
        #1;

        // Registered path: one valid 1+1+0, then hold with in_valid low
        step(1, 1, 0, 1, 0, 0, 0);
        check("reg_capture", {5'd0, bus.out_valid, bus.sum_q, bus.carry_q}, 8'b101);
        step(0, 0, 1, 0, 0, 0, 0);
        check("reg_hold", {5'd0, bus.out_valid, bus.sum_q, bus.carry_q}, 8'b001);

        // Counter saturation at CNT_W = 2, then clear beating a qualifying carry
        step(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 1, $urandom_range(0, 1), 1, 0, 0, 0);
            check("cnt_sat", {6'd0, bus.carry_cnt}, {6'd0, cnt_exp[i]});
        end
        step(1, 1, 0, 1, 1, 0, 0);
        check("cnt_clr_priority", {6'd0, bus.carry_cnt}, 8'd0);

`ifdef FULL_ADDER_SERIAL_EN
        // 3 + 1 LSB-first; ser_start on bit 0 with cin = 0
        for (int i = 0; i < 4; i++) begin
            step(ser_a[i], ser_b[i], 0, 1, 0, 1, (i == 0));
            check("serial_sum_bit", {7'd0, last_s}, {7'd0, ser_exp[i]});
        end
`else
        // Serial feature absent: cin goes straight through even after a carry
        step(1, 1, 0, 1, 0, 1, 0);
        step(0, 0, 1, 1, 0, 1, 0);
        check("noserial_sum", {7'd0, last_s}, 8'd1);
        check("noserial_carry", {7'd0, last_c}, 8'd0);
`endif

        // Load sum_q = 1 and carry_cnt = 2, then reset between edges
        step(0, 0, 0, 0, 1, 0, 0);
        step(1, 1, 0, 1, 0, 0, 0);
        step(1, 1, 0, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0);
        check("pre_reset_load", {4'd0, bus.sum_q, bus.carry_q, bus.carry_cnt}, 8'b1010);
        bus.in_valid = 0; bus.cnt_clr = 0;
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", {3'd0, bus.out_valid, bus.sum_q, bus.carry_q, bus.carry_cnt}, 8'd0);
        model_reset();
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 1), 0, 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
